// File: rtl/nes_pal_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : nes_pal_pkg                                                     |
// | Purpose  : Shared constants, palette entry record and loader FSM states    |
// |            for the NES custom palette loader.                              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package nes_pal_pkg;

  localparam int PAL_ENTRIES     = 64;
  localparam int BYTES_PER_ENTRY = 3;
  localparam int PAL_BYTES       = PAL_ENTRIES * BYTES_PER_ENTRY;

  // One palette RAM write: target entry plus {R,G,B}.
  typedef struct packed {
    logic [5:0]  index;
    logic [23:0] rgb;
  } pal_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    FLUSH = 2'd2
  } pal_state_t;

endpackage
`default_nettype wire

// File: rtl/nes_pal_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : nes_pal_loader_if                                               |
// | Purpose  : Download byte-stream bus between the file downloader (master)   |
// |            and the palette loader (slave).                                 |
// | Signals  : dl_active - download in progress (level)                        |
// |            dl_wr     - one-cycle byte strobe                               |
// |            dl_addr   - byte offset within the file                         |
// |            dl_data   - file byte                                           |
// |            dl_wait   - backpressure, no dl_wr allowed while high           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface nes_pal_loader_if;
  logic        dl_active;
  logic        dl_wr;
  logic [12:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_wait;

  modport master (output dl_active, dl_wr, dl_addr, dl_data, input dl_wait);
  modport slave  (input dl_active, dl_wr, dl_addr, dl_data, output dl_wait);
endinterface
`default_nettype wire

// File: rtl/pal_entry_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pal_entry_fifo                                                  |
// | Purpose  : Two-deep FIFO of assembled palette entries.                     |
// | Ports    : clk, reset_n (sync, active-low), flush (sync empty),            |
// |            push/push_data, pop/head (first-word fall-through), count       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module pal_entry_fifo
  import nes_pal_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flush,
  input  logic       push,
  input  pal_entry_t push_data,
  input  logic       pop,
  output pal_entry_t head,
  output logic [1:0] count
);

  pal_entry_t r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       w_do_push;
  logic       w_do_pop;

  assign w_do_pop  = pop && (r_count != 2'd0);
  // A push into a full FIFO is accepted only when the head leaves on the same edge.
  assign w_do_push = push && ((r_count != 2'd2) || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/nes_pal_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : nes_pal_loader                                                  |
// | Purpose  : Assembles a downloaded palette file into 64 RGB entries and     |
// |            writes them to the custom palette RAM, optionally only during   |
// |            blanking. Reports completeness / errors of the last download.   |
// | Ports    : clk, reset_n (sync, active-low)                                 |
// |            dl               - download bus (slave side)                    |
// |            write_allow      - blanking window (used when GATE_WRITES=1)    |
// |            load_color       - one-cycle palette RAM write strobe           |
// |            load_color_index - entry being written                          |
// |            load_color_data  - {R,G,B}                                      |
// |            pal_valid        - last download delivered 64 clean entries     |
// |            pal_error        - sticky error for current/last download       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module nes_pal_loader
  import nes_pal_pkg::*;
#(
  parameter bit          GATE_WRITES = 1'b1,
  parameter int unsigned MAX_BYTES   = 1536
) (
  input  logic                    clk,
  input  logic                    reset_n,
  nes_pal_loader_if.slave         dl,
  input  logic                    write_allow,
  output logic                    load_color,
  output logic [5:0]              load_color_index,
  output logic [23:0]             load_color_data,
  output logic                    pal_valid,
  output logic                    pal_error
);

  localparam logic [12:0] c_max_bytes = 13'(MAX_BYTES);
  localparam logic [12:0] c_pal_bytes = 13'(PAL_BYTES);

  pal_state_t  r_state, w_state_nxt;

  // Input stage: the byte strobe and dl_active are registered once so that
  // a completed entry is never visible to the write issue logic earlier than
  // two edges after its last byte was sampled.
  logic        r_act_d1, r_act_d2;
  logic        r_wr, r_wr_full;
  logic [12:0] r_addr;
  logic [7:0]  r_data;

  logic [12:0] r_byte_cnt;
  logic [1:0]  r_lane;
  logic [6:0]  r_entry;
  logic [7:0]  r_red, r_grn;

  logic        w_rise, w_fall;
  logic        w_start, w_end_recv, w_finish;
  logic        w_byte_seen, w_byte_ok, w_byte_err, w_in_pal;
  logic        w_push, w_push_lost, w_issue;
  logic        w_fifo_full, w_fifo_empty;
  logic [1:0]  w_fifo_count;
  pal_entry_t  w_push_entry, w_head;

  assign w_rise = r_act_d1 && !r_act_d2;
  assign w_fall = !r_act_d1 && r_act_d2;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_end_recv  = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_nxt = RECV;
          w_start     = 1'b1;
        end
      end
      RECV: begin
        if (w_fall) begin
          w_state_nxt = FLUSH;
          w_end_recv  = 1'b1;
        end
      end
      FLUSH: begin
        if (w_rise) begin
          w_state_nxt = RECV;
          w_start     = 1'b1;
        end else if (w_fifo_empty) begin
          w_state_nxt = IDLE;
          w_finish    = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  assign w_byte_seen = (r_state == RECV) && r_wr;
  assign w_byte_ok   = w_byte_seen && !r_wr_full && (r_addr == r_byte_cnt) &&
                       (r_byte_cnt < c_max_bytes);
  assign w_byte_err  = w_byte_seen && !w_byte_ok;
  assign w_in_pal    = r_byte_cnt < c_pal_bytes;
  assign w_push      = w_byte_ok && w_in_pal && (r_lane == 2'd2);

  assign w_push_entry = '{index: r_entry[5:0], rgb: {r_red, r_grn, r_data}};

  assign w_fifo_full  = (w_fifo_count == 2'd2);
  assign w_fifo_empty = (w_fifo_count == 2'd0);
  // Entries left over from an interrupted download are discarded, not written.
  assign w_issue      = !w_fifo_empty && (!GATE_WRITES || write_allow) && !w_start;
  assign w_push_lost  = w_push && w_fifo_full && !w_issue;

  assign dl.dl_wait = w_fifo_full;

  pal_entry_fifo u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (w_start),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_issue),
    .head      (w_head),
    .count     (w_fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_act_d1         <= 1'b0;
      r_act_d2         <= 1'b0;
      r_wr             <= 1'b0;
      r_wr_full        <= 1'b0;
      r_addr           <= '0;
      r_data           <= '0;
      r_byte_cnt       <= '0;
      r_lane           <= '0;
      r_entry          <= '0;
      r_red            <= '0;
      r_grn            <= '0;
      load_color       <= 1'b0;
      load_color_index <= '0;
      load_color_data  <= '0;
      pal_valid        <= 1'b0;
      pal_error        <= 1'b0;
    end else begin
      r_act_d1  <= dl.dl_active;
      r_act_d2  <= r_act_d1;
      r_wr      <= dl.dl_wr;
      // A strobe while full violates dl_wait; remember that at sample time.
      r_wr_full <= dl.dl_wr && w_fifo_full;
      r_addr    <= dl.dl_addr;
      r_data    <= dl.dl_data;

      load_color <= w_issue;
      if (w_issue) begin
        load_color_index <= w_head.index;
        load_color_data  <= w_head.rgb;
      end

      if (w_start) begin
        r_byte_cnt <= '0;
        r_lane     <= '0;
        r_entry    <= '0;
        pal_valid  <= 1'b0;
        pal_error  <= 1'b0;
      end else begin
        // Falling with a partially assembled entry discards that entry.
        if (w_byte_err || w_push_lost || (w_end_recv && (r_lane != 2'd0))) begin
          pal_error <= 1'b1;
        end
        if (w_byte_ok) begin
          r_byte_cnt <= r_byte_cnt + 13'd1;
          if (w_in_pal) begin
            case (r_lane)
              2'd0: begin
                r_red  <= r_data;
                r_lane <= 2'd1;
              end
              2'd1: begin
                r_grn  <= r_data;
                r_lane <= 2'd2;
              end
              default: begin
                r_lane  <= 2'd0;
                r_entry <= r_entry + 7'd1;
              end
            endcase
          end
        end
        if (w_finish) begin
          pal_valid <= (r_entry == 7'(PAL_ENTRIES)) && !pal_error;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nes_pal_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_nes_pal_loader                                               |
// | Purpose  : Scoreboard bench for nes_pal_loader. Two instances share one    |
// |            byte stream: dut0 writes ungated, dut1 gated by write_allow.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_nes_pal_loader;
  import nes_pal_pkg::*;

  localparam int MAXB = 1536;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        dl_active, dl_wr, write_allow;
  logic [12:0] dl_addr;
  logic [7:0]  dl_data;
  logic        lc0, lc1, pv0, pv1, pe0, pe1;
  logic [5:0]  idx0, idx1;
  logic [23:0] dat0, dat1;

  always #5 clk = ~clk;

  nes_pal_loader_if bus0 ();
  nes_pal_loader_if bus1 ();
  assign bus0.dl_active = dl_active;
  assign bus0.dl_wr     = dl_wr;
  assign bus0.dl_addr   = dl_addr;
  assign bus0.dl_data   = dl_data;
  assign bus1.dl_active = dl_active;
  assign bus1.dl_wr     = dl_wr;
  assign bus1.dl_addr   = dl_addr;
  assign bus1.dl_data   = dl_data;

  nes_pal_loader #(.GATE_WRITES(1'b0), .MAX_BYTES(MAXB)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .dl(bus0.slave), .write_allow(write_allow),
    .load_color(lc0), .load_color_index(idx0), .load_color_data(dat0),
    .pal_valid(pv0), .pal_error(pe0));

  nes_pal_loader #(.GATE_WRITES(1'b1), .MAX_BYTES(MAXB)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .dl(bus1.slave), .write_allow(write_allow),
    .load_color(lc1), .load_color_index(idx1), .load_color_data(dat1),
    .pal_valid(pv1), .pal_error(pe1));

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int wa_mode  = 0;   // 0 hold low, 1 hold high, 2 random blanking
  logic wa_q;

  pal_entry_t exp_q0[$];
  pal_entry_t exp_q1[$];
  int pulse_cyc0[$];
  int pulse_cyc1[$];

  // Reference model: a file is a sequence of bytes; a byte is accepted only
  // if it carries the next expected offset and the file is not yet full.
  int        m_cnt;
  int        m_pushed;
  bit        m_err;
  logic [7:0] m_rgb [3];
  int        last_byte_cyc;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) wa_q <= write_allow;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endfunction

  function automatic void score(input int which, input logic [5:0] idx, input logic [23:0] rgb);
    pal_entry_t e;
    if ((which == 0 && exp_q0.size() == 0) || (which == 1 && exp_q1.size() == 0)) begin
      n_checks++;
      $display("FAIL dut%0d_unexpected_write: got index %0d data %06h, expected no write", which, idx, rgb);
      return;
    end
    if (which == 0) e = exp_q0.pop_front();
    else            e = exp_q1.pop_front();
    check($sformatf("dut%0d_index", which), 32'(idx), 32'(e.index));
    check($sformatf("dut%0d_data_idx%0d", which, e.index), 32'(rgb), 32'(e.rgb));
  endfunction

  always @(negedge clk) begin
    if (lc0) begin
      pulse_cyc0.push_back(cyc);
      score(0, idx0, dat0);
    end
    if (lc1) begin
      pulse_cyc1.push_back(cyc);
      check("dut1_write_in_blanking", 32'(wa_q), 32'd1);
      score(1, idx1, dat1);
    end
  end

  initial begin
    write_allow = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (wa_mode)
        0:       write_allow = 1'b0;
        1:       write_allow = 1'b1;
        default: write_allow = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  task automatic model_byte(input logic [12:0] a, input logic [7:0] d);
    pal_entry_t e;
    if (int'(a) != m_cnt || m_cnt >= MAXB) begin
      m_err = 1'b1;
    end else begin
      if (m_cnt < PAL_BYTES) begin
        m_rgb[m_cnt % 3] = d;
        if (m_cnt % 3 == 2) begin
          e.index = 6'(m_cnt / 3);
          e.rgb   = {m_rgb[0], m_rgb[1], m_rgb[2]};
          exp_q0.push_back(e);
          exp_q1.push_back(e);
          m_pushed++;
        end
      end
      m_cnt++;
    end
  endtask

  task automatic send_byte(input logic [12:0] a, input logic [7:0] d);
    int guard = 0;
    while ((bus0.dl_wait || bus1.dl_wait) && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 5000) check("dl_wait_timeout", 32'(bus0.dl_wait | bus1.dl_wait), 32'd0);
    dl_wr = 1'b1; dl_addr = a; dl_data = d;
    @(posedge clk); #1;
    last_byte_cyc = cyc;
    dl_wr = 1'b0;
    model_byte(a, d);
  endtask

  task automatic start_download(input string tag);
    m_cnt = 0; m_pushed = 0; m_err = 1'b0;
    pulse_cyc0.delete();
    pulse_cyc1.delete();
    dl_active = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check({tag, "_valid_cleared"}, 32'(pv0 | pv1), 32'd0);
    check({tag, "_error_cleared"}, 32'(pe0 | pe1), 32'd0);
  endtask

  task automatic end_download(input string tag);
    int  guard = 0;
    bit  exp_err, exp_valid;
    dl_active = 1'b0;
    exp_err   = m_err || (m_cnt < PAL_BYTES && (m_cnt % 3) != 0);
    exp_valid = (m_cnt >= PAL_BYTES) && !exp_err;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && guard < 4000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 4000) check({tag, "_drain"}, 32'(exp_q0.size() + exp_q1.size()), 32'd0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check({tag, "_dut0_writes"}, 32'(pulse_cyc0.size()), 32'(m_pushed));
    check({tag, "_dut1_writes"}, 32'(pulse_cyc1.size()), 32'(m_pushed));
    check({tag, "_dut0_valid"},  32'(pv0), 32'(exp_valid));
    check({tag, "_dut0_error"},  32'(pe0), 32'(exp_err));
    check({tag, "_dut1_valid"},  32'(pv1), 32'(exp_valid));
    check({tag, "_dut1_error"},  32'(pe1), 32'(exp_err));
    @(posedge clk); #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_load_color"}, 32'({lc0, lc1}), 32'd0);
    check({tag, "_index"},      32'({idx0, idx1}), 32'd0);
    check({tag, "_data0"},      32'(dat0), 32'd0);
    check({tag, "_data1"},      32'(dat1), 32'd0);
    check({tag, "_valid"},      32'({pv0, pv1}), 32'd0);
    check({tag, "_error"},      32'({pe0, pe1}), 32'd0);
    check({tag, "_dl_wait"},    32'({bus0.dl_wait, bus1.dl_wait}), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k2;
    reset_n = 1'b0; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;

    // Sequential bytes, one strobe every 4 cycles, random blanking.
    wa_mode = 2;
    start_download("t1");
    k2 = 0;
    for (int i = 0; i < PAL_BYTES; i++) begin
      send_byte(13'(i), 8'(i));
      if (i == 2) k2 = last_byte_cyc;
      repeat (3) begin @(posedge clk); #1; end
    end
    if (pulse_cyc0.size() > 0) check("t1_first_write_latency_ge2", 32'(pulse_cyc0[0] - k2 >= 2), 32'd1);
    end_download("t1");

    // Blanking held off: FIFO fills, backpressure, then two back-to-back writes.
    wa_mode = 0;
    repeat (3) begin @(posedge clk); #1; end
    start_download("t2");
    fork
      begin
        for (int i = 0; i < 9; i++) send_byte(13'(i), 8'($urandom));
      end
      begin
        int g = 0;
        while (!bus1.dl_wait && g < 200) begin @(posedge clk); #1; g++; end
        check("t2_dl_wait_high", 32'(bus1.dl_wait), 32'd1);
        repeat (6) begin @(posedge clk); #1; end
        check("t2_no_write_while_blanked", 32'(pulse_cyc1.size()), 32'd0);
        wa_mode = 1;
        g = 0;
        while (pulse_cyc1.size() < 2 && g < 200) begin @(posedge clk); #1; g++; end
        if (pulse_cyc1.size() >= 2) check("t2_back_to_back", 32'(pulse_cyc1[1] - pulse_cyc1[0]), 32'd1);
        else check("t2_two_writes", 32'(pulse_cyc1.size()), 32'd2);
        g = 0;
        while (bus1.dl_wait && g < 200) begin @(posedge clk); #1; g++; end
        check("t2_dl_wait_low", 32'(bus1.dl_wait), 32'd0);
      end
    join
    end_download("t2");

    // Maximum-size file, then one byte too many.
    wa_mode = 2;
    start_download("t3");
    for (int i = 0; i < MAXB; i++) send_byte(13'(i), 8'($urandom));
    end_download("t3");
    start_download("t4");
    for (int i = 0; i <= MAXB; i++) send_byte(13'(i), 8'($urandom));
    end_download("t4");

    // Out-of-order byte is dropped without shifting later entries.
    start_download("t5");
    for (int i = 0; i < PAL_BYTES; i++) begin
      if (i == 6) send_byte(13'd7, 8'($urandom));
      send_byte(13'(i), 8'($urandom));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    end_download("t5");

    // Download cut short in the middle of an entry.
    start_download("t6");
    for (int i = 0; i < 100; i++) send_byte(13'(i), 8'($urandom));
    end_download("t6");

    // Reset mid-download: nothing pending may be written afterwards.
    start_download("t7");
    for (int i = 0; i < 50; i++) send_byte(13'(i), 8'($urandom));
    reset_n = 1'b0; dl_active = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_q0.delete();
    exp_q1.delete();
    @(negedge clk);
    check_outputs_zero("t7_after_reset");
    wa_mode = 1;
    repeat (20) begin @(posedge clk); #1; end
    wa_mode = 2;

    start_download("t8");
    for (int i = 0; i < PAL_BYTES; i++) send_byte(13'(i), 8'($urandom));
    end_download("t8");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
